// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator add/subtract datapath.
package calc_pkg;

    typedef enum logic {OP_ADD, OP_SUB} calc_op_t;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} addsub_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/addsub_seq_unit_if.sv
// Operand-side and result-side valid/ready bundle for the sequential add/subtract unit.
interface addsub_seq_unit_if #(
    parameter int N = 6
);

    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative
    );

endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice, reused every cycle by the sequencer.
module addsub_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[CHUNK];
    end

endmodule

// File: rtl/addsub_seq_unit.sv
// Multi-cycle two's-complement add/subtract engine, CHUNK bits per clock, with status flags.
// Optional signed saturation of the result is enabled by defining ADDSUB_SATURATE_EN.
module addsub_seq_unit
    import calc_pkg::*;
#(
    parameter int N     = 6,
    parameter int CHUNK = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    addsub_seq_unit_if.slave bus
);

    localparam int NCHUNK = ceil_div(N, CHUNK);
    localparam int W      = NCHUNK * CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    addsub_state_t   state, state_nxt;
    calc_op_t        op_r;
    logic [W-1:0]    a_r, b_r;
    logic [W:0]      acc, acc_nxt;
    logic            cy_r;
    logic [IDXW-1:0] idx;
    logic            load, step, finish;
    int              base;

    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             cout_chunk;
    logic [N-1:0]     b_eff;

    logic [N-1:0] result_r, res_nxt, sum_n;
    logic         carry_r, overflow_r, zero_r, negative_r;
    logic         raw_c, carry_nxt, ovf_nxt;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (cy_r),
        .sum  (sum_chunk),
        .cout (cout_chunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // acc[W] captures the final chunk carry; with zero padding above N, acc[N] is always the true carry
    always_comb begin
        base    = int'(idx) * CHUNK;
        a_chunk = a_r[base +: CHUNK];
        b_chunk = b_r[base +: CHUNK];
        acc_nxt = acc;
        acc_nxt[base +: CHUNK] = sum_chunk;
        if (idx == LAST_IDX) acc_nxt[W] = cout_chunk;
        b_eff = bus.op ? ~bus.b : bus.b;
    end

    always_comb begin
        sum_n     = acc_nxt[N-1:0];
        raw_c     = acc_nxt[N];
        carry_nxt = (op_r == OP_SUB) ? ~raw_c : raw_c;
        ovf_nxt   = (a_r[N-1] == b_r[N-1]) && (acc_nxt[N-1] != a_r[N-1]);
`ifdef ADDSUB_SATURATE_EN
        if (ovf_nxt) res_nxt = a_r[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else         res_nxt = sum_n;
`else
        res_nxt = sum_n;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            acc        <= '0;
            cy_r       <= 1'b0;
            op_r       <= OP_ADD;
            idx        <= '0;
            result_r   <= '0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            if (load) begin
                a_r  <= W'(bus.a);
                b_r  <= W'(b_eff);
                acc  <= '0;
                cy_r <= bus.op;
                op_r <= calc_op_t'(bus.op);
                idx  <= '0;
            end else if (step) begin
                acc  <= acc_nxt;
                cy_r <= cout_chunk;
                if (!finish) idx <= idx + IDXW'(1);
            end
            if (finish) begin
                result_r   <= res_nxt;
                carry_r    <= carry_nxt;
                overflow_r <= ovf_nxt;
                zero_r     <= ~|res_nxt;
                negative_r <= res_nxt[N-1];
            end
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_r;
    assign bus.carry     = carry_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;
    assign bus.negative  = negative_r;

endmodule

// File: tb/tb_addsub_seq_unit.sv
// Self-checking bench for addsub_seq_unit: N=6/CHUNK=2 and N=7/CHUNK=3 instances, vectors plus random ops.
module tb_addsub_seq_unit;

    typedef struct {
        logic        op;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        neg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   failed   = 0;

    always #5 clk = ~clk;

    addsub_seq_unit_if #(.N(6)) bus6();
    addsub_seq_unit_if #(.N(7)) bus7();

    addsub_seq_unit #(.N(6), .CHUNK(2)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
    addsub_seq_unit #(.N(7), .CHUNK(3)) dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

    // Reference: plain integer arithmetic on unsigned and signed views of the operands
    function automatic void refModel(input int n, input logic op, input longint a, input longint b,
                                     output logic [31:0] res, output logic c, output logic v,
                                     output logic z, output logic ng);
        longint span, half, sa, sb, sr, ur, r;
        span = longint'(1) << n;
        half = span / 2;
        sa   = (a >= half) ? a - span : a;
        sb   = (b >= half) ? b - span : b;
        sr   = op ? sa - sb : sa + sb;
        ur   = op ? a - b : a + b;
        r    = ur & (span - 1);
        c    = op ? (a < b) : (ur >= span);
        v    = (sr >= half) || (sr < -half);
`ifdef ADDSUB_SATURATE_EN
        if (v) r = (sa < 0) ? half : half - 1;
`endif
        res = 32'(r);
        z   = (r == 0);
        ng  = (r >= half);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBus6(input string tag, input logic [31:0] er, input logic ec,
                             input logic ev, input logic ez, input logic en);
        checkOutput({tag, ".valid"},    32'(bus6.out_valid), 32'd1);
        checkOutput({tag, ".result"},   32'(bus6.result),    er);
        checkOutput({tag, ".carry"},    32'(bus6.carry),     32'(ec));
        checkOutput({tag, ".overflow"}, 32'(bus6.overflow),  32'(ev));
        checkOutput({tag, ".zero"},     32'(bus6.zero),      32'(ez));
        checkOutput({tag, ".negative"}, 32'(bus6.negative),  32'(en));
    endtask

    task automatic checkBus7(input string tag, input logic [31:0] er, input logic ec,
                             input logic ev, input logic ez, input logic en);
        checkOutput({tag, ".valid"},    32'(bus7.out_valid), 32'd1);
        checkOutput({tag, ".result"},   32'(bus7.result),    er);
        checkOutput({tag, ".carry"},    32'(bus7.carry),     32'(ec));
        checkOutput({tag, ".overflow"}, 32'(bus7.overflow),  32'(ev));
        checkOutput({tag, ".zero"},     32'(bus7.zero),      32'(ez));
        checkOutput({tag, ".negative"}, 32'(bus7.negative),  32'(en));
    endtask

    // Presents one op, returns with the DUT in its first out_valid cycle; lat counts cycles after acceptance
    task automatic applyStimulus(input logic op, input logic [5:0] a, input logic [5:0] b, output int lat);
        int waitc;
        waitc = 0;
        bus6.op = op; bus6.a = a; bus6.b = b; bus6.in_valid = 1'b1;
        while (!bus6.in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        checkOutput("accept6", 32'(bus6.in_ready), 32'd1);
        @(posedge clk); #1;
        bus6.in_valid = 1'b0;
        lat = 1;
        while (!bus6.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic applyStimulus7(input logic op, input logic [6:0] a, input logic [6:0] b, output int lat);
        int waitc;
        waitc = 0;
        bus7.op = op; bus7.a = a; bus7.b = b; bus7.in_valid = 1'b1;
        while (!bus7.in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        checkOutput("accept7", 32'(bus7.in_ready), 32'd1);
        @(posedge clk); #1;
        bus7.in_valid = 1'b0;
        lat = 1;
        while (!bus7.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        int          lat;
        int          sawvalid;
        logic        rop, ec, ev, ez, en;
        logic [5:0]  ra, rb;
        logic [6:0]  sa7, sb7;
        logic [31:0] er;

        vecs[0] = '{1'b1, 6'd5,  6'd3,  32'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 6'd3,  6'd5,  32'h3E, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SATURATE_EN
        vecs[2] = '{1'b0, 6'd31, 6'd1,  32'h1F, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        vecs[2] = '{1'b0, 6'd31, 6'd1,  32'h20, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        vecs[3] = '{1'b0, 6'd63, 6'd1,  32'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 6'd9,  6'd9,  32'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 6'd7,  6'd0,  32'h07, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SATURATE_EN
        vecs[6] = '{1'b1, 6'd0,  6'd32, 32'h1F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 6'd32, 6'd32, 32'h20, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[6] = '{1'b1, 6'd0,  6'd32, 32'h20, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 6'd32, 6'd32, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

        bus6.in_valid = 1'b0; bus6.op = 1'b0; bus6.a = '0; bus6.b = '0; bus6.out_ready = 1'b1;
        bus7.in_valid = 1'b0; bus7.op = 1'b0; bus7.a = '0; bus7.b = '0; bus7.out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset.in_ready",  32'(bus6.in_ready),  32'd1);
        checkOutput("reset.out_valid", 32'(bus6.out_valid), 32'd0);
        checkOutput("reset.result",    32'(bus6.result),    32'd0);
        checkOutput("reset.flags", 32'({bus6.carry, bus6.overflow, bus6.zero, bus6.negative}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed vectors, N=6 CHUNK=2");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d.latency", i), 32'(lat), 32'd4);
            checkBus6($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].neg);
        end

        $display("[TB] random ops, N=6 CHUNK=2");
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = 6'($urandom_range(0, 63));
            rb  = 6'($urandom_range(0, 63));
            refModel(6, rop, longint'(ra), longint'(rb), er, ec, ev, ez, en);
            applyStimulus(rop, ra, rb, lat);
            checkOutput("rand6.latency", 32'(lat), 32'd4);
            checkBus6($sformatf("rand6[%0d]", i), er, ec, ev, ez, en);
        end

        $display("[TB] backpressure");
        @(posedge clk); #1;
        bus6.out_ready = 1'b0;
        applyStimulus(1'b1, 6'd20, 6'd7, lat);
        checkOutput("bp.latency", 32'(lat), 32'd4);
        checkBus6("bp.first", 32'd13, 1'b0, 1'b0, 1'b0, 1'b0);
        bus6.op = 1'b0; bus6.a = 6'd10; bus6.b = 6'd12; bus6.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp.hold_valid",  32'(bus6.out_valid), 32'd1);
            checkOutput("bp.hold_ready",  32'(bus6.in_ready),  32'd0);
            checkOutput("bp.hold_result", 32'(bus6.result),    32'd13);
        end
        bus6.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp.release_valid", 32'(bus6.out_valid), 32'd0);
        checkOutput("bp.release_ready", 32'(bus6.in_ready),  32'd1);
        @(posedge clk); #1;
        checkOutput("bp.accepted", 32'(bus6.in_ready), 32'd0);
        bus6.in_valid = 1'b0;
        lat = 1;
        while (!bus6.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp.second_latency", 32'(lat), 32'd4);
        refModel(6, 1'b0, 64'd10, 64'd12, er, ec, ev, ez, en);
        checkBus6("bp.second", er, ec, ev, ez, en);
        @(posedge clk); #1;

        $display("[TB] N=7 CHUNK=3");
        applyStimulus7(1'b0, 7'h7F, 7'h01, lat);
        checkOutput("n7.latency", 32'(lat), 32'd4);
        checkBus7("n7.wrap", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            rop = 1'($urandom_range(0, 1));
            sa7 = 7'($urandom_range(0, 127));
            sb7 = 7'($urandom_range(0, 127));
            refModel(7, rop, longint'(sa7), longint'(sb7), er, ec, ev, ez, en);
            applyStimulus7(rop, sa7, sb7, lat);
            checkOutput("rand7.latency", 32'(lat), 32'd4);
            checkBus7($sformatf("rand7[%0d]", i), er, ec, ev, ez, en);
        end
        refModel(7, 1'b0, 64'h25, 64'h30, er, ec, ev, ez, en);
        applyStimulus7(1'b0, 7'h25, 7'h30, lat);
        checkBus7("n7.pre_reset", er, ec, ev, ez, en);
        @(posedge clk); #1;

        $display("[TB] reset during CALC");
        bus7.op = 1'b0; bus7.a = 7'd3; bus7.b = 7'd4; bus7.in_valid = 1'b1;
        @(posedge clk); #1;
        bus7.in_valid = 1'b0;
        checkOutput("abort.in_calc", 32'(bus7.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.in_ready",  32'(bus7.in_ready),  32'd1);
        checkOutput("abort.out_valid", 32'(bus7.out_valid), 32'd0);
        checkOutput("abort.result",    32'(bus7.result),    32'd0);
        checkOutput("abort.flags", 32'({bus7.carry, bus7.overflow, bus7.zero, bus7.negative}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sawvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus7.out_valid) sawvalid++;
        end
        checkOutput("abort.no_valid", 32'(sawvalid), 32'd0);
        checkOutput("abort.idle", 32'(bus7.in_ready), 32'd1);
        refModel(7, 1'b1, 64'd3, 64'd5, er, ec, ev, ez, en);
        applyStimulus7(1'b1, 7'd3, 7'd5, lat);
        checkOutput("abort.recover_latency", 32'(lat), 32'd4);
        checkBus7("abort.recover", er, ec, ev, ez, en);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/addsub_seq_unit.md
Name: addsub_seq_unit

Overview:
- Parametrised, multi-cycle two's-complement add/subtract engine for the calculator datapath, with status flags; next generation of the combinational n-bit subtractor.
- Processes CHUNK bits per clock (ripple across cycles) to bound the critical path for wide N on the FPGA.
- Sits between the operand/keypad register stage and the display/result register, using valid/ready handshakes on both sides.

Parameters:
- N, 6, operand/result width in bits (N >= 2)
- CHUNK, 2, bits added per clock cycle (1 <= CHUNK <= N); NCHUNK = ceil(N/CHUNK) is a derived localparam

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op are valid this cycle
- in_ready  out  1  unit accepts a new operation
- op  in  1  0 = add (a+b), 1 = subtract (a-b)
- a  in  N  first operand
- b  in  N  second operand
- out_valid  out  1  result and flags are valid
- out_ready  in  1  consumer accepts the result
- result  out  N  sum/difference, modulo 2^N
- carry  out  1  add: carry out of bit N-1; sub: borrow (1 when unsigned a < b)
- overflow  out  1  signed two's-complement overflow
- zero  out  1  result == 0
- negative  out  1  result[N-1]

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result, carry, overflow, zero and negative all 0; chunk counter and internal carry 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a into a_r and b_eff into b_r. For add, b_eff=b; for sub, b_eff=~b. Both are zero-extended to NCHUNK*CHUNK bits. Set the carry register to op (carry-in 1 for subtract), latch op into op_r, idx=0, go to CALC.
  - CALC: in_ready=0. Each cycle, add chunk idx of a_r and b_r plus the carry register, write the sum into chunk idx of the accumulator, and update the carry register. When idx==NCHUNK-1, go to DONE; otherwise idx++.
  - DONE: out_valid=1 with outputs stable. When out_ready=1, go to IDLE (out_valid=0 on the next cycle). When out_ready=0, hold indefinitely.
- Flag derivation (in the cycle entering DONE):
  - result = acc[N-1:0].
  - Raw carry c = acc[N], which is valid because of zero padding above N. carry = op_r ? ~c : c.
  - overflow = (a_r[N-1] == b_r[N-1]) && (acc[N-1] != a_r[N-1]), using the inverted b for subtract.
  - zero = ~|acc[N-1:0]; negative = acc[N-1].
- Latency: acceptance to out_valid is exactly NCHUNK+1 cycles. Throughput is one op per NCHUNK+2 cycles with out_ready held high. No overlap: in_ready=0 during CALC and DONE.
- Outputs are registered and hold their last values while not in DONE; out_valid qualifies them.
- An in_valid asserted outside IDLE is ignored. The upstream must hold in_valid until it sees in_ready.
- If N is not a multiple of CHUNK, the top chunk is partial. Padding bits of a_r and b_r are 0, so acc[N] is the true carry.
- Async reset mid-CALC or mid-DONE aborts the operation with no out_valid pulse; the state after reset is as listed above.
- Edge cases:
  - a == b on subtract: result 0, zero=1, carry=0.
  - b == 0 on subtract: carry=0.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined: when overflow=1, result clamps to the signed limit. It is 2^(N-1)-1 if a_r[N-1]==0, else -2^(N-1). Flags are still computed from the unclamped sum, and negative/zero reflect the clamped result.
- Undefined: result wraps modulo 2^N. There is no clamp logic.

Decomposition:
- Package calc_pkg:
  - typedef enum logic {OP_ADD, OP_SUB} calc_op_t
  - typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} addsub_state_t
  - function for ceil-div, used for NCHUNK
- One sub-module, addsub_chunk: combinational CHUNK-bit ripple adder with cin/cout. It is instantiated once and muxed by idx.

Test Plan:
- N=6, CHUNK=2, sub a=5, b=3, out_ready=1 -> out_valid 4 cycles after acceptance; result=2, carry=0, overflow=0, zero=0, negative=0.
- Sub a=3, b=5 -> result=6'h3E, carry=1, negative=1, overflow=0.
- Add a=31, b=1 -> result=6'h20, overflow=1, negative=1, carry=0. With ADDSUB_SATURATE_EN -> result=6'h1F, negative=0, overflow=1.
- Add a=63, b=1 -> result=0, zero=1, carry=1, overflow=0. Sub a=9, b=9 -> result=0, zero=1, carry=0.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and result held, in_ready=0, a second in_valid ignored. Releasing out_ready -> IDLE next cycle and the new op is accepted.
- N=7, CHUNK=3: add 7'h7F + 1 -> result=0, carry=1. Also pulse rst_n low during CALC -> out_valid never asserts, all outputs 0, in_ready=1.
